pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Supervises the fabric PLL. Drives the PLL reset input, consumes the PLL's asynchronous locked output, and produces a clean system reset for downstream logic.
- System reset releases only after lock has been continuously stable for a programmable time.
- Retries the PLL on lock timeout and declares a fault after a bounded number of retries.
- Runs on the PLL reference clock, so it is alive while the PLL is not.

Parameters:
SYNC_STAGES, 2, synchronizer flops on pll_locked_i (min 2)
PLL_RST_CYCLES, 16, cycles pll_rst_o is held high per PLL reset pulse (min 1)
LOCK_STABLE_CYCLES, 1024, cycles synchronized lock must stay high before release (min 1)
LOCK_TIMEOUT_CYCLES, 125000, cycles allowed in WAIT_LOCK before a retry (1 ms at 125 MHz)
MAX_RETRIES, 7, retries after the initial attempt before FAULT (max 15)
CNT_W, 24, state counter width; must hold max(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)

Ports:
refclk  in  1  reference clock; sole clock
rst  in  1  asynchronous, active-high reset
pll_locked_i  in  1  PLL locked, asynchronous to refclk
force_relock_i  in  1  single-cycle request to restart PLL bring-up
pll_rst_o  out  1  to PLL rst input, active high
sys_rst_o  out  1  system reset, active high
locked_stable_o  out  1  high only in RUN
fault_o  out  1  retry budget exhausted
retry_count_o  out  4  retries consumed in current bring-up

Behaviour:
- One clock: refclk. Reset rst is asynchronous, active-high.
- Reset values, applied immediately with no clock:
  - state = RESET_PLL, counter 0, synchronizer 0
  - pll_rst_o = 1, sys_rst_o = 1, locked_stable_o = 0, fault_o = 0, retry_count_o = 0
- lock_s is pll_locked_i passed through SYNC_STAGES flops. The FSM uses only lock_s.
- The counter clears on every state entry and increments every cycle in the state.
- All outputs are registered and change on the same edge as the state. No combinational path from any input to any output.
- RESET_PLL:
  - pll_rst_o = 1, sys_rst_o = 1.
  - After exactly PLL_RST_CYCLES cycles -> WAIT_LOCK.
  - force_relock_i is ignored.
- WAIT_LOCK:
  - pll_rst_o = 0.
  - lock_s = 1 -> STABLE_WAIT.
  - Else if counter == LOCK_TIMEOUT_CYCLES-1:
    - retry_count == MAX_RETRIES -> FAULT.
    - Otherwise retry_count++ and -> RESET_PLL.
  - If lock_s and the timeout occur in the same cycle, lock wins.
- STABLE_WAIT:
  - lock_s = 0 on any cycle -> WAIT_LOCK. The timeout restarts; no retry is consumed.
  - counter == LOCK_STABLE_CYCLES-1 with lock_s = 1 -> RUN.
- RUN:
  - On entry: sys_rst_o = 0, locked_stable_o = 1, retry_count cleared.
  - lock_s = 0 -> RESET_PLL. sys_rst_o = 1 and locked_stable_o = 0 on that same edge.
- FAULT:
  - pll_rst_o = 1, sys_rst_o = 1, fault_o = 1.
  - Exits only on rst, or on force_relock_i, which clears fault_o and retry_count and goes -> RESET_PLL.
- force_relock_i:
  - In WAIT_LOCK, STABLE_WAIT or RUN -> RESET_PLL; retry_count is not incremented.
  - It has priority over every other transition in those states.
- Latency: with the FSM in WAIT_LOCK and pll_locked_i first sampled high at edge k (held high), sys_rst_o falls at edge k + SYNC_STAGES + LOCK_STABLE_CYCLES.
- retry_count_o saturates by construction. It never exceeds MAX_RETRIES.

Optional Feature:
Macro: PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
- Defined:
  - Adds output lock_loss_cnt_o [15:0].
  - It counts RUN -> RESET_PLL transitions caused by lock_s falling; force_relock_i does not count.
  - Saturates at 16'hFFFF and clears only on rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
All tests use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, SYNC_STAGES=2.
1. Release rst; raise pll_locked_i 10 cycles after pll_rst_o falls and hold it -> pll_rst_o high for exactly 4 cycles; sys_rst_o falls exactly 10 edges after locked is first sampled; locked_stable_o rises on the same edge.
2. In STABLE_WAIT, drop pll_locked_i for 1 cycle after 5 stable cycles -> sys_rst_o stays 1; return to WAIT_LOCK; release needs a fresh full 8 cycles; retry_count_o stays 0.
3. Hold pll_locked_i = 0 -> three 4-cycle pll_rst_o pulses separated by 32-cycle WAIT_LOCK windows; retry_count_o steps 1, 2; fault_o = 1 after the third timeout; pll_rst_o stays 1.
4. In FAULT, pulse force_relock_i, then supply lock -> fault_o = 0, retry_count_o = 0, new 4-cycle pll_rst_o pulse, normal release as in test 1.
5. In RUN, drop pll_locked_i -> sys_rst_o = 1 on the edge after lock_s falls; 4-cycle pll_rst_o pulse follows; with the macro defined, lock_loss_cnt_o increments 0 -> 1.
6. Assert rst asynchronously mid STABLE_WAIT with no clock edge -> all outputs take reset values immediately; after release, the sequence restarts from RESET_PLL.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Brings up the fabric PLL and produces a clean system reset. The PLL reset is
// pulsed, lock is awaited with a timeout, and lock must then hold continuously
// for a programmable time before the system reset is released. A timeout leads
// to a retry, and FAULT is entered once the retry budget is spent. The block
// runs on the PLL reference clock, so it keeps running while the PLL is down.
//
// Ports:
//   refclk           reference clock (only clock)
//   rst              asynchronous, active-high reset
//   pll_locked_i     PLL locked indication, asynchronous to refclk
//   force_relock_i   single-cycle request to restart PLL bring-up
//   pll_rst_o        PLL reset, active high
//   sys_rst_o        system reset, active high
//   locked_stable_o  high only while in RUN
//   fault_o          retry budget exhausted
//   retry_count_o    retries consumed in the current bring-up
//   lock_loss_cnt_o  (PLL_LOCK_SUPERVISOR_LOSS_CNT_EN only) saturating count
//                    of lock losses seen while in RUN
//
// Optional feature macro: PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 24
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked_i,
  input  logic       force_relock_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       locked_stable_o,
  output logic       fault_o,
  output logic [3:0] retry_count_o
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  ,
  output logic [15:0] lock_loss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_RESET_PLL   = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_STABLE_WAIT = 3'd2,
    ST_RUN         = 3'd3,
    ST_FAULT       = 3'd4
  } state_e;

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle window is N-1.
  localparam logic [CNT_W-1:0] RST_LAST_C     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST_C  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST_C = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE_C      = CNT_W'(1);
  localparam logic [3:0]       MAX_RETRY_C    = 4'(MAX_RETRIES);

  state_e                 state_r;
  state_e                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [3:0]             retry_r;
  logic [3:0]             retry_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;

  logic pll_rst_r, sys_rst_r, stable_r, fault_r;
  logic pll_rst_s, sys_rst_s, stable_s, fault_s;

  assign lock_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain bringing the asynchronous lock indication into refclk.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  // State register together with the registered outputs and retry count.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RESET_PLL;
      retry_r   <= 4'd0;
      pll_rst_r <= 1'b1;
      sys_rst_r <= 1'b1;
      stable_r  <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      retry_r   <= retry_s;
      pll_rst_r <= pll_rst_s;
      sys_rst_r <= sys_rst_s;
      stable_r  <= stable_s;
      fault_r   <= fault_s;
    end
  end

  // Per-state cycle counter: restarts on every state change, otherwise counts
  // up and parks at all-ones so long stays in RUN or FAULT never wrap.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_s != state_r) begin
      cnt_r <= '0;
    end else if (cnt_r != '1) begin
      cnt_r <= cnt_r + CNT_ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next-state and retry bookkeeping; force_relock_i outranks every other
  // exit from WAIT_LOCK, STABLE_WAIT and RUN.
  always_comb begin
    state_s = state_r;
    retry_s = retry_r;
    case (state_r)
      ST_RESET_PLL: begin
        if (cnt_r == RST_LAST_C) begin
          state_s = ST_WAIT_LOCK;
        end else begin
          state_s = ST_RESET_PLL;
        end
      end
      ST_WAIT_LOCK: begin
        if (force_relock_i) begin
          state_s = ST_RESET_PLL;
        end else if (lock_s) begin
          // Lock beats a timeout landing on the same cycle.
          state_s = ST_STABLE_WAIT;
        end else if (cnt_r == TIMEOUT_LAST_C) begin
          if (retry_r == MAX_RETRY_C) begin
            state_s = ST_FAULT;
          end else begin
            retry_s = retry_r + 4'd1;
            state_s = ST_RESET_PLL;
          end
        end else begin
          state_s = ST_WAIT_LOCK;
        end
      end
      ST_STABLE_WAIT: begin
        if (force_relock_i) begin
          state_s = ST_RESET_PLL;
        end else if (!lock_s) begin
          // A glitch sends us back to wait without spending a retry.
          state_s = ST_WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST_C) begin
          state_s = ST_RUN;
          retry_s = 4'd0;
        end else begin
          state_s = ST_STABLE_WAIT;
        end
      end
      ST_RUN: begin
        if (force_relock_i || !lock_s) begin
          state_s = ST_RESET_PLL;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (force_relock_i) begin
          state_s = ST_RESET_PLL;
          retry_s = 4'd0;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s = ST_RESET_PLL;
        retry_s = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so the output registers switch on the
  // same edge as the state register.
  always_comb begin
    pll_rst_s = 1'b1;
    sys_rst_s = 1'b1;
    stable_s  = 1'b0;
    fault_s   = 1'b0;
    case (state_s)
      ST_RESET_PLL: begin
        pll_rst_s = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABLE_WAIT: begin
        pll_rst_s = 1'b0;
      end
      ST_RUN: begin
        pll_rst_s = 1'b0;
        sys_rst_s = 1'b0;
        stable_s  = 1'b1;
      end
      ST_FAULT: begin
        fault_s = 1'b1;
      end
      default: begin
        pll_rst_s = 1'b1;
      end
    endcase
  end

  assign pll_rst_o       = pll_rst_r;
  assign sys_rst_o       = sys_rst_r;
  assign locked_stable_o = stable_r;
  assign fault_o         = fault_r;
  assign retry_count_o   = retry_r;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic [15:0] loss_cnt_r;

  // Saturating count of RUN exits caused by lock loss (forced exits excluded).
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt_r <= 16'd0;
    end else if ((state_r == ST_RUN) && !force_relock_i && !lock_s &&
                 (loss_cnt_r != 16'hFFFF)) begin
      loss_cnt_r <= loss_cnt_r + 16'd1;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign lock_loss_cnt_o = loss_cnt_r;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int SYNC = 2;
  localparam int PRC  = 4;
  localparam int LSC  = 8;
  localparam int LTC  = 32;
  localparam int MAXR = 2;

  // Reference-model phases.
  localparam int P_RST   = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked_i;
  logic       force_relock_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       locked_stable_o;
  logic       fault_o;
  logic [3:0] retry_count_o;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
  logic [15:0] lock_loss_cnt_o;
`endif

  pll_lock_supervisor #(
    .SYNC_STAGES        (SYNC),
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES        (MAXR),
    .CNT_W              (24)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked_i   (pll_locked_i),
    .force_relock_i (force_relock_i),
    .pll_rst_o      (pll_rst_o),
    .sys_rst_o      (sys_rst_o),
    .locked_stable_o(locked_stable_o),
    .fault_o        (fault_o),
    .retry_count_o  (retry_count_o)
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    ,
    .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
  );

  always #5 refclk = ~refclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model state: phase, cycles spent in it, retries, loss count,
  // and a delay line standing in for the synchronizer latency.
  int m_phase;
  int m_age;
  int m_retry;
  int m_loss;
  int lq[$];

  typedef struct {
    bit locked;
    bit force_rl;
    bit e_pll;
    bit e_sys;
    bit e_ls;
    bit e_fault;
    int e_retry;
  } vec_t;
  vec_t vt[$];

  function automatic void add(int n, bit lk, bit fr, bit p, bit s, bit l, bit f, int r);
    for (int i = 0; i < n; i++) vt.push_back('{lk, fr, p, s, l, f, r});
  endfunction

  function automatic logic [7:0] outs();
    return {pll_rst_o, sys_rst_o, locked_stable_o, fault_o, retry_count_o};
  endfunction

  function automatic logic [7:0] model_outs();
    logic [3:0] r;
    r = 4'(m_retry);
    return {(m_phase == P_RST) || (m_phase == P_FAULT), m_phase != P_RUN,
            m_phase == P_RUN, m_phase == P_FAULT, r};
  endfunction

  function automatic void model_reset();
    m_phase = P_RST;
    m_age   = 0;
    m_retry = 0;
    m_loss  = 0;
    lq      = {};
    for (int i = 0; i < SYNC; i++) lq.push_back(0);
  endfunction

  function automatic void model_step(bit lk, bit fr);
    int seen;
    int nxt;
    seen = lq.pop_front();
    lq.push_back(int'(lk));
    nxt = m_phase;
    case (m_phase)
      P_RST:   if (m_age + 1 >= PRC) nxt = P_WAIT;
      P_WAIT: begin
        if (fr) nxt = P_RST;
        else if (seen != 0) nxt = P_STAB;
        else if (m_age + 1 >= LTC) begin
          if (m_retry >= MAXR) nxt = P_FAULT;
          else begin
            m_retry++;
            nxt = P_RST;
          end
        end
      end
      P_STAB: begin
        if (fr) nxt = P_RST;
        else if (seen == 0) nxt = P_WAIT;
        else if (m_age + 1 >= LSC) nxt = P_RUN;
      end
      P_RUN: begin
        if (fr) nxt = P_RST;
        else if (seen == 0) begin
          nxt = P_RST;
          if (m_loss < 65535) m_loss++;
        end
      end
      P_FAULT: begin
        if (fr) begin
          nxt = P_RST;
          m_retry = 0;
        end
      end
      default: nxt = P_RST;
    endcase
    if (nxt == P_RUN) m_retry = 0;
    if (nxt != m_phase) m_age = 0;
    else m_age++;
    m_phase = nxt;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: inputs already stable, sample outputs 1 ns after the edge.
  task automatic tick();
    bit lk;
    bit fr;
    lk = pll_locked_i;
    fr = force_relock_i;
    @(posedge refclk);
    #1;
    cyc++;
    model_step(lk, fr);
    check("model", int'(outs()), int'(model_outs()));
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    check("model_loss", int'(lock_loss_cnt_o), m_loss);
`endif
  endtask

  task automatic run_to(int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked_i = 1'b0;
    force_relock_i = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    model_reset();
    check("reset_vals", int'(outs()), int'(8'b1100_0000));
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    check("reset_loss", int'(lock_loss_cnt_o), 0);
`endif
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lvl;
    int run_left;
    rst = 1'b1;
    pll_locked_i = 1'b0;
    force_relock_i = 1'b0;
    #2;
    check("reset_async_t0", int'(outs()), int'(8'b1100_0000));

    // Test 1: table of edges 1..27 after reset release, lock first sampled at edge 14.
    add(3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    add(10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add(10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    add(4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      logic [3:0] er;
      pll_locked_i   = vt[i].locked;
      force_relock_i = vt[i].force_rl;
      tick();
      er = 4'(vt[i].e_retry);
      check($sformatf("t1[%0d]", i), int'(outs()),
            int'({vt[i].e_pll, vt[i].e_sys, vt[i].e_ls, vt[i].e_fault, er}));
    end

    // Test 2: one-cycle lock glitch in STABLE_WAIT restarts the stable window.
    do_reset();
    run_to(4);
    pll_locked_i = 1'b1;
    run_to(9);
    pll_locked_i = 1'b0;
    run_to(10);
    pll_locked_i = 1'b1;
    run_to(15);
    check("t2_no_early_release", int'(sys_rst_o), 1);
    run_to(20);
    check("t2_sys_hold", int'(sys_rst_o), 1);
    check("t2_retry", int'(retry_count_o), 0);
    run_to(21);
    check("t2_release", int'({sys_rst_o, locked_stable_o}), 1);

    // Test 3: no lock -> retries then FAULT.
    do_reset();
    run_to(35);
    check("t3_wait0", int'({pll_rst_o, retry_count_o}), 0);
    run_to(36);
    check("t3_retry1", int'({pll_rst_o, retry_count_o}), 'h11);
    run_to(39);
    check("t3_pulse1_end", int'(pll_rst_o), 1);
    run_to(40);
    check("t3_pulse1_fall", int'(pll_rst_o), 0);
    run_to(72);
    check("t3_retry2", int'({pll_rst_o, retry_count_o}), 'h12);
    run_to(107);
    check("t3_prefault", int'({fault_o, pll_rst_o}), 0);
    run_to(108);
    check("t3_fault", int'({fault_o, pll_rst_o, sys_rst_o, retry_count_o}), 'h72);
    run_to(130);
    check("t3_fault_hold", int'({fault_o, pll_rst_o}), 3);

    // Test 4: force_relock out of FAULT, then normal bring-up.
    force_relock_i = 1'b1;
    tick();
    force_relock_i = 1'b0;
    check("t4_exit", int'({fault_o, pll_rst_o, retry_count_o}), 'h10);
    run_to(134);
    check("t4_pulse_end", int'(pll_rst_o), 1);
    run_to(135);
    check("t4_pulse_fall", int'(pll_rst_o), 0);
    pll_locked_i = 1'b1;
    run_to(145);
    check("t4_sys_hold", int'(sys_rst_o), 1);
    run_to(146);
    check("t4_release", int'({sys_rst_o, locked_stable_o, retry_count_o}), 'h10);

    // Test 5: lock loss in RUN.
    run_to(150);
    pll_locked_i = 1'b0;
    run_to(152);
    check("t5_still_run", int'({sys_rst_o, locked_stable_o}), 1);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    check("t5_loss0", int'(lock_loss_cnt_o), 0);
`endif
    run_to(153);
    check("t5_drop", int'({sys_rst_o, locked_stable_o, pll_rst_o}), 'b101);
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    check("t5_loss1", int'(lock_loss_cnt_o), 1);
`endif
    run_to(156);
    check("t5_pulse_end", int'(pll_rst_o), 1);
    run_to(157);
    check("t5_pulse_fall", int'(pll_rst_o), 0);

    // Test 6: asynchronous reset mid STABLE_WAIT, no clock edge.
    do_reset();
    pll_locked_i = 1'b1;
    run_to(8);
    check("t6_in_stable", int'(outs()), int'(8'b0100_0000));
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_vals", int'(outs()), int'(8'b1100_0000));
    @(posedge refclk);
    #1;
    model_reset();
    rst = 1'b0;
    cyc = 0;
    run_to(3);
    check("t6_restart_pll", int'(pll_rst_o), 1);
    run_to(4);
    check("t6_restart_fall", int'(pll_rst_o), 0);
    run_to(13);
    check("t6_release", int'({sys_rst_o, locked_stable_o}), 1);

    // Randomized run against the model.
    do_reset();
    lvl = 0;
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        lvl = int'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 80));
      end
      pll_locked_i = (lvl != 0);
      run_left--;
      force_relock_i = ($urandom_range(0, 63) == 0);
      tick();
    end
    force_relock_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
